mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage directly downstream of execute. Consumes exec_data_t and issues
//  loads/stores on the data bus (dbus_req_t/dbus_resp_t) with byte strobes.
//  Aligns and extends load data, and flags misaligned accesses.
//  Registers the result into mem_data_t for writeback, stalling upstream while a
//  bus transaction is outstanding.
// PARAMETERS
//  XLEN      64  datapath width; word_t width.
//  MAX_WAIT  255 bus wait cycles before bus_timeout pulses (diagnostic only).
// PORTS
//  clk          in   1       clock; all state on posedge.
//  reset        in   1       synchronous, active-high.
//  valid_in     in   1       dataE holds a live instruction this cycle.
//  dataE        in   struct  exec_data_t from execute (ctl.op, aluout=addr, rd=store data).
//  dreq         out  struct  dbus_req_t: valid, addr, size, strobe, data.
//  dresp        in   struct  dbus_resp_t: addr_ok, data_ok, data.
//  stall        out  1       hold execute/decode/fetch; dataE must stay stable.
//  valid_out    out  1       dataM is live (registered).
//  dataM        out  struct  mem_data_t: ctl, dst, instr, result, misalign, csr fields.
//  bus_timeout  out  1       one-cycle pulse when a wait reaches MAX_WAIT.
// BEHAVIOUR
//  Reset: state=IDLE; valid_out=0; dataM='0; dreq.valid=0; stall=0; wait counter=0; bus_timeout=0.
//  Classification: mem op = LB,LH,LW,LD,LBU,LHU,LWU,SB,SH,SW,SD. All other ops pass through.
//  Non-mem op with valid_in in IDLE:
//   - Register into dataM next edge; dataM.result=dataE.aluout; valid_out=1; no stall.
//  Alignment check on addr=dataE.aluout:
//   - B is always aligned; H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
//   - On misalign: no bus request, no stall. Register next edge with dataM.misalign=1, result=addr.
//  FSM states IDLE, REQ, DONE:
//   - IDLE -> REQ: aligned mem op with valid_in. dreq.valid goes high combinationally this same cycle.
//     stall=1 this same cycle.
//   - REQ: dreq fields are held constant and stall=1.
//     On dresp.data_ok, the next edge registers dataM and sets valid_out=1.
//     stall drops in that same data_ok cycle, so execute advances on the same edge. Next state is DONE.
//   - Same-cycle addr_ok+data_ok is legal and completes in 1 cycle.
//   - DONE: one cycle with dreq.valid=0. This guarantees the next request is a fresh transaction.
//     Returns to IDLE. A new valid_in in DONE is stalled 1 cycle.
//  Request encoding (o = addr[2:0]):
//   - dreq.addr=addr (unaligned, byte address).
//   - size = MSIZE1/2/4/8 for B/H/W/D.
//   - Store strobe = {1,3,15,255}<<o for B/H/W/D. Store data = dataE.rd << (8*o).
//   - Loads: strobe=0, data=0.
//  Load result:
//   - raw = dresp.data >> (8*o), then truncate to the access size.
//   - LB/LH/LW sign-extend to 64; LBU/LHU/LWU zero-extend; LD takes the full raw value.
//   - Stores: dataM.result=0.
//  valid_out:
//   - 1 for exactly one cycle per completed instruction.
//   - 0 while in REQ before data_ok, and 0 when valid_in=0.
//  Wait counter:
//   - Counts REQ cycles and saturates at MAX_WAIT.
//   - bus_timeout pulses once when it reaches MAX_WAIT; the FSM keeps waiting. Cleared on leaving REQ.
//  Reset mid-transaction: next edge returns to IDLE, dreq.valid=0, and valid_out=0. A late data_ok is ignored.
// TESTING
//  1. ADD, aluout=0x1234, valid_in -> next cycle valid_out=1, dataM.result=0x1234; stall=0 throughout.
//  2. SB, rd=0xAB, addr=0x80000005 -> dreq.strobe=0x20, dreq.data=0x0000AB0000000000, size=MSIZE1.
//     Fields stable for 3 stall cycles until data_ok.
//  3. LB at addr=0x...3, dresp.data=0x00000000_80000000 -> result=0xFFFFFFFFFFFFFF80.
//     LBU at the same addr -> result 0x80.
//  4. LW, addr=0x...2 -> no dreq.valid, no stall; next cycle valid_out=1, misalign=1, result=addr.
//  5. LD with addr_ok and data_ok in the same cycle -> one stall cycle, then DONE;
//     back-to-back SD stalls 1 extra cycle, then a new request.
//  6. reset asserted in REQ -> next edge dreq.valid=0, valid_out=0, state=IDLE; data_ok 2 cycles later -> no output.

Source files
------------

// File: rtl/mem_access_if.sv
// Shared pipeline/bus types and the data-bus interface between the memory stage and the bus.
// The package lives here so the interface and the stage see the same definitions.
package mem_access_pkg;
   localparam int XLEN = 64;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
      OP_SB, OP_SH, OP_SW, OP_SD
   } decoded_op_t;

   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef struct packed {
      decoded_op_t op;
      logic        reg_write;
   } control_t;

   typedef struct packed {
      control_t    ctl;
      logic [4:0]  dst;
      logic [31:0] instr;
      word_t       aluout;
      word_t       rd;
      logic        csr_write;
      logic [11:0] csr_addr;
      word_t       csr_wdata;
   } exec_data_t;

   typedef struct packed {
      control_t    ctl;
      logic [4:0]  dst;
      logic [31:0] instr;
      word_t       result;
      logic        misalign;
      logic        csr_write;
      logic [11:0] csr_addr;
      word_t       csr_wdata;
   } mem_data_t;

   typedef struct packed {
      logic       valid;
      word_t      addr;
      msize_t     size;
      logic [7:0] strobe;
      word_t      data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;
endpackage

interface mem_access_if;
   import mem_access_pkg::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);
endinterface

// File: rtl/mem_access.sv
// Memory stage: issues aligned loads/stores on the data bus, aligns/extends load data,
// flags misaligned accesses and registers the result for writeback.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  exec_data_t dataE,
   mem_access_if.master dbus,
   output logic       stall,
   output logic       valid_out,
   output mem_data_t  dataM,
   output logic       bus_timeout
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;

   logic       is_mem;
   logic       is_load;
   logic       misaligned;
   logic       issue;
   logic       complete;
   msize_t     size;
   logic [2:0] offset;
   logic [5:0] shamt;
   logic [7:0] strobe_base;
   word_t      raw;
   word_t      load_result;
   mem_data_t  next_dataM;
   logic       unused_addr_ok;

   // The request is fire-and-hold until data_ok, so address acceptance carries no extra meaning here.
   assign unused_addr_ok = dbus.dresp.addr_ok;

   assign offset = dataE.aluout[2:0];
   assign shamt  = {offset, 3'b000};

   always_comb begin
      is_mem      = 1'b1;
      is_load     = 1'b1;
      size        = MSIZE1;
      case (dataE.ctl.op)
         OP_LB, OP_LBU: size = MSIZE1;
         OP_LH, OP_LHU: size = MSIZE2;
         OP_LW, OP_LWU: size = MSIZE4;
         OP_LD:         size = MSIZE8;
         OP_SB: begin is_load = 1'b0; size = MSIZE1; end
         OP_SH: begin is_load = 1'b0; size = MSIZE2; end
         OP_SW: begin is_load = 1'b0; size = MSIZE4; end
         OP_SD: begin is_load = 1'b0; size = MSIZE8; end
         default: begin is_mem = 1'b0; is_load = 1'b0; end
      endcase

      misaligned  = 1'b0;
      strobe_base = 8'h01;
      case (size)
         MSIZE1: begin misaligned = 1'b0;             strobe_base = 8'h01; end
         MSIZE2: begin misaligned = offset[0];        strobe_base = 8'h03; end
         MSIZE4: begin misaligned = |offset[1:0];     strobe_base = 8'h0F; end
         MSIZE8: begin misaligned = |offset;          strobe_base = 8'hFF; end
         default: begin misaligned = 1'b0;            strobe_base = 8'h01; end
      endcase
   end

   assign issue    = (state == IDLE) && valid_in && is_mem && !misaligned;
   assign complete = ((state == IDLE) && valid_in && !issue) ||
                     ((state == REQ) && dbus.dresp.data_ok);

   // Request fields come straight from dataE, which upstream holds steady while we stall.
   always_comb begin
      dbus.dreq       = '0;
      dbus.dreq.valid = issue || (state == REQ);
      dbus.dreq.addr  = dataE.aluout;
      dbus.dreq.size  = size;
      if (is_mem && !is_load) begin
         dbus.dreq.strobe = strobe_base << offset;
         dbus.dreq.data   = dataE.rd << shamt;
      end
   end

   // A new instruction arriving in DONE waits one cycle so the bus sees a fresh request.
   assign stall = issue ||
                  ((state == REQ) && !dbus.dresp.data_ok) ||
                  ((state == DONE) && valid_in);

   always_comb begin
      raw = dbus.dresp.data >> shamt;
      case (dataE.ctl.op)
         OP_LB:   load_result = {{56{raw[7]}},  raw[7:0]};
         OP_LBU:  load_result = {56'd0,         raw[7:0]};
         OP_LH:   load_result = {{48{raw[15]}}, raw[15:0]};
         OP_LHU:  load_result = {48'd0,         raw[15:0]};
         OP_LW:   load_result = {{32{raw[31]}}, raw[31:0]};
         OP_LWU:  load_result = {32'd0,         raw[31:0]};
         OP_LD:   load_result = raw;
         default: load_result = '0;
      endcase

      next_dataM           = '0;
      next_dataM.ctl       = dataE.ctl;
      next_dataM.dst       = dataE.dst;
      next_dataM.instr     = dataE.instr;
      next_dataM.csr_write = dataE.csr_write;
      next_dataM.csr_addr  = dataE.csr_addr;
      next_dataM.csr_wdata = dataE.csr_wdata;
      next_dataM.misalign  = is_mem && misaligned;
      next_dataM.result    = (!is_mem || misaligned) ? dataE.aluout : load_result;
   end

   // Stage FSM, writeback register and bus wait watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         valid_out   <= 1'b0;
         dataM       <= '0;
         wait_cnt    <= '0;
         bus_timeout <= 1'b0;
      end else begin
         valid_out   <= complete;
         bus_timeout <= 1'b0;
         if (complete) begin
            dataM <= next_dataM;
         end
         case (state)
            IDLE: begin
               if (issue) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (dbus.dresp.data_ok) begin
                  state    <= DONE;
                  wait_cnt <= '0;
               end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                  wait_cnt    <= wait_cnt + WAIT_W'(1);
                  bus_timeout <= (wait_cnt == WAIT_W'(MAX_WAIT - 1));
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single instructions plus
// hand-written sequences for back-to-back, mid-transaction reset and bus timeout.
module tb_mem_access;
   import mem_access_pkg::*;

   typedef struct {
      decoded_op_t op;
      logic [63:0] addr;
      logic [63:0] rd;
      logic [63:0] rdata;
      int          waits;
      logic        exp_req;
      msize_t      exp_size;
      logic [7:0]  exp_strobe;
      logic [63:0] exp_wdata;
      logic [63:0] exp_result;
      logic        exp_misalign;
   } vec_t;

   localparam int NV = 18;

   logic       clk;
   logic       reset;
   logic       valid_in;
   exec_data_t data_e;
   logic       stall;
   logic       valid_out;
   mem_data_t  data_m;
   logic       bus_timeout;
   int         tests_run;
   int         tests_failed;
   string      tag;
   vec_t       vecs [NV];

   mem_access_if bus ();

   mem_access #(.MAX_WAIT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .dataE      (data_e),
      .dbus       (bus.master),
      .stall      (stall),
      .valid_out  (valid_out),
      .dataM      (data_m),
      .bus_timeout(bus_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s %s: got 0x%h, expected 0x%h", tag, name, actual, expected);
      end
   endtask

   function automatic vec_t mk(decoded_op_t op, logic [63:0] addr, logic [63:0] rd, logic [63:0] rdata,
                               int waits, logic exp_req, msize_t exp_size, logic [7:0] exp_strobe,
                               logic [63:0] exp_wdata, logic [63:0] exp_result, logic exp_misalign);
      vec_t v;
      v.op = op; v.addr = addr; v.rd = rd; v.rdata = rdata; v.waits = waits;
      v.exp_req = exp_req; v.exp_size = exp_size; v.exp_strobe = exp_strobe;
      v.exp_wdata = exp_wdata; v.exp_result = exp_result; v.exp_misalign = exp_misalign;
      return v;
   endfunction

   function automatic exec_data_t mk_exec(decoded_op_t op, logic [63:0] addr, logic [63:0] rd);
      exec_data_t e;
      e           = '0;
      e.ctl.op    = op;
      e.ctl.reg_write = 1'b1;
      e.dst       = 5'd7;
      e.instr     = 32'h0000_0013;
      e.aluout    = addr;
      e.rd        = rd;
      return e;
   endfunction

   task automatic apply_stimulus(input vec_t v, input int idx);
      exec_data_t e;
      e = mk_exec(v.op, v.addr, v.rd);
      e.dst = 5'(idx + 1);
      tag = $sformatf("v%0d", idx);
      @(posedge clk); #1;
      data_e   = e;
      valid_in = 1'b1;
      bus.dresp = '0;
      @(negedge clk);
      check_output("req_valid", 64'(bus.dreq.valid), 64'(v.exp_req));
      check_output("stall_first", 64'(stall), 64'(v.exp_req));
      if (v.exp_req) begin
         check_output("addr", bus.dreq.addr, v.addr);
         check_output("size", 64'(bus.dreq.size), 64'(v.exp_size));
         check_output("strobe", 64'(bus.dreq.strobe), 64'(v.exp_strobe));
         check_output("wdata", bus.dreq.data, v.exp_wdata);
         @(posedge clk); #1;
         for (int k = 0; k < v.waits; k++) begin
            @(negedge clk);
            check_output("stall_wait", 64'(stall), 64'd1);
            check_output("strobe_held", 64'(bus.dreq.strobe), 64'(v.exp_strobe));
            check_output("wdata_held", bus.dreq.data, v.exp_wdata);
            check_output("valid_out_wait", 64'(valid_out), 64'd0);
            @(posedge clk); #1;
         end
         bus.dresp.addr_ok = 1'b1;
         bus.dresp.data_ok = 1'b1;
         bus.dresp.data    = v.rdata;
         @(negedge clk);
         check_output("stall_data_ok", 64'(stall), 64'd0);
         @(posedge clk); #1;
         valid_in  = 1'b0;
         bus.dresp = '0;
      end else begin
         @(posedge clk); #1;
         valid_in = 1'b0;
      end
      @(negedge clk);
      check_output("valid_out", 64'(valid_out), 64'd1);
      check_output("result", data_m.result, v.exp_result);
      check_output("misalign", 64'(data_m.misalign), 64'(v.exp_misalign));
      check_output("dst", 64'(data_m.dst), 64'(idx + 1));
      if (v.exp_req) begin
         check_output("done_req_valid", 64'(bus.dreq.valid), 64'd0);
      end
   endtask

   initial begin
      int first_pulse;
      int pulses;

      tests_run    = 0;
      tests_failed = 0;
      tag          = "reset";
      reset        = 1'b1;
      valid_in     = 1'b0;
      data_e       = '0;
      bus.dresp    = '0;

      vecs[0]  = mk(OP_ADD, 64'h1234, 64'h0, 64'h0, 0, 1'b0, MSIZE1, 8'h00, 64'h0, 64'h1234, 1'b0);
      vecs[1]  = mk(OP_SB,  64'h8000_0005, 64'hAB, 64'h0, 2, 1'b1, MSIZE1, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 1'b0);
      vecs[2]  = mk(OP_LB,  64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1, 1'b1, MSIZE1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      vecs[3]  = mk(OP_LBU, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1, 1'b1, MSIZE1, 8'h00, 64'h0, 64'h80, 1'b0);
      vecs[4]  = mk(OP_LW,  64'h8000_0002, 64'h0, 64'h0, 0, 1'b0, MSIZE4, 8'h00, 64'h0, 64'h8000_0002, 1'b1);
      vecs[5]  = mk(OP_LH,  64'h1006, 64'h0, 64'h8765_4321_0000_0000, 0, 1'b1, MSIZE2, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 1'b0);
      vecs[6]  = mk(OP_LHU, 64'h1006, 64'h0, 64'h8765_4321_0000_0000, 0, 1'b1, MSIZE2, 8'h00, 64'h0, 64'h8765, 1'b0);
      vecs[7]  = mk(OP_LW,  64'h1004, 64'h0, 64'h89AB_CDEF_0123_4567, 1, 1'b1, MSIZE4, 8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
      vecs[8]  = mk(OP_LWU, 64'h1004, 64'h0, 64'h89AB_CDEF_0123_4567, 0, 1'b1, MSIZE4, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0);
      vecs[9]  = mk(OP_LD,  64'h1008, 64'h0, 64'h1122_3344_5566_7788, 3, 1'b1, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
      vecs[10] = mk(OP_SH,  64'h2002, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0, 1, 1'b1, MSIZE2, 8'h0C, 64'hFFFF_FFFF_BEEF_0000, 64'h0, 1'b0);
      vecs[11] = mk(OP_SW,  64'h2004, 64'h0000_0000_CAFE_BABE, 64'h0, 0, 1'b1, MSIZE4, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0, 1'b0);
      vecs[12] = mk(OP_SD,  64'h2010, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1'b1, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
      vecs[13] = mk(OP_SD,  64'h200C, 64'h55, 64'h0, 0, 1'b0, MSIZE8, 8'h00, 64'h0, 64'h200C, 1'b1);
      vecs[14] = mk(OP_LH,  64'h3001, 64'h0, 64'h0, 0, 1'b0, MSIZE2, 8'h00, 64'h0, 64'h3001, 1'b1);
      vecs[15] = mk(OP_SUB, 64'hDEAD_BEEF, 64'h0, 64'h0, 0, 1'b0, MSIZE1, 8'h00, 64'h0, 64'hDEAD_BEEF, 1'b0);
      vecs[16] = mk(OP_SB,  64'h4007, 64'h5A, 64'h0, 0, 1'b1, MSIZE1, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 1'b0);
      vecs[17] = mk(OP_LB,  64'h4001, 64'h0, 64'h0000_0000_0000_7F00, 0, 1'b1, MSIZE1, 8'h00, 64'h0, 64'h7F, 1'b0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("valid_out", 64'(valid_out), 64'd0);
      check_output("stall", 64'(stall), 64'd0);
      check_output("req_valid", 64'(bus.dreq.valid), 64'd0);
      check_output("dataM_zero", 64'(data_m == '0), 64'd1);
      check_output("bus_timeout", 64'(bus_timeout), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         apply_stimulus(vecs[i], i);
      end

      // LD completing in one REQ cycle, then an SD held off by DONE.
      tag = "b2b";
      @(posedge clk); #1;
      data_e   = mk_exec(OP_LD, 64'h100, 64'h0);
      valid_in = 1'b1;
      @(negedge clk);
      check_output("ld_stall", 64'(stall), 64'd1);
      check_output("ld_req", 64'(bus.dreq.valid), 64'd1);
      @(posedge clk); #1;
      bus.dresp.addr_ok = 1'b1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = 64'hA5A5_0000_FFFF_1234;
      @(negedge clk);
      check_output("ld_stall_ok", 64'(stall), 64'd0);
      @(posedge clk); #1;
      bus.dresp = '0;
      data_e    = mk_exec(OP_SD, 64'h108, 64'hCAFE_F00D_1234_5678);
      valid_in  = 1'b1;
      @(negedge clk);
      check_output("ld_valid_out", 64'(valid_out), 64'd1);
      check_output("ld_result", data_m.result, 64'hA5A5_0000_FFFF_1234);
      check_output("done_stall", 64'(stall), 64'd1);
      check_output("done_req", 64'(bus.dreq.valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_output("sd_req", 64'(bus.dreq.valid), 64'd1);
      check_output("sd_stall", 64'(stall), 64'd1);
      check_output("sd_strobe", 64'(bus.dreq.strobe), 64'hFF);
      check_output("sd_data", bus.dreq.data, 64'hCAFE_F00D_1234_5678);
      check_output("sd_no_valid_out", 64'(valid_out), 64'd0);
      @(posedge clk); #1;
      bus.dresp.data_ok = 1'b1;
      @(negedge clk);
      check_output("sd_stall_ok", 64'(stall), 64'd0);
      @(posedge clk); #1;
      valid_in  = 1'b0;
      bus.dresp = '0;
      @(negedge clk);
      check_output("sd_valid_out", 64'(valid_out), 64'd1);
      check_output("sd_result", data_m.result, 64'h0);

      // Reset while a load is waiting; a late data_ok must produce nothing.
      tag = "rst_req";
      @(posedge clk); #1;
      data_e   = mk_exec(OP_LW, 64'h200, 64'h0);
      valid_in = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b1;
      valid_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_output("req_valid", 64'(bus.dreq.valid), 64'd0);
      check_output("valid_out", 64'(valid_out), 64'd0);
      check_output("stall", 64'(stall), 64'd0);
      check_output("dataM_dst", 64'(data_m.dst), 64'd0);
      @(posedge clk); #1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      check_output("late_req_valid", 64'(bus.dreq.valid), 64'd0);
      @(posedge clk); #1;
      bus.dresp = '0;
      @(negedge clk);
      check_output("late_valid_out", 64'(valid_out), 64'd0);

      // Long wait: bus_timeout pulses once on the 256th REQ cycle while the stage keeps waiting.
      tag = "timeout";
      first_pulse = 0;
      pulses      = 0;
      @(posedge clk); #1;
      data_e   = mk_exec(OP_LB, 64'h300, 64'h0);
      valid_in = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (bus_timeout) begin
            pulses++;
            if (first_pulse == 0) first_pulse = n;
         end
         @(posedge clk); #1;
      end
      check_output("first_pulse", 64'(first_pulse), 64'd256);
      check_output("pulse_count", 64'(pulses), 64'd1);
      @(negedge clk);
      check_output("still_stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = 64'h0000_0000_0000_007F;
      @(posedge clk); #1;
      bus.dresp = '0;
      valid_in  = 1'b0;
      @(negedge clk);
      check_output("valid_out", 64'(valid_out), 64'd1);
      check_output("result", data_m.result, 64'h7F);
      check_output("timeout_low", 64'(bus_timeout), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
